pi_switch_sched: RTL and testbench



---
 rtl/pi_sched_pkg.sv | 59 +++++
 rtl/pi_switch_sched_decode.sv | 32 +++
 rtl/pi_switch_sched.sv | 189 ++++++++++++++++++
 tb/tb_pi_switch_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_sched_pkg.sv
// Shared types and constants for the pi switch scheduler: direction and
// select codes, input/output index constants, packet field offsets and the
// allocation record passed from the allocator to the output crossbar.
package pi_sched_pkg;

    typedef enum logic [1:0] {
        VOID  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        UP    = 2'b11
    } dir_t;

    // Crossbar source selects, one per input link.
    typedef enum logic [1:0] {
        SEL_UPR   = 2'b00,
        SEL_LEFT  = 2'b01,
        SEL_RIGHT = 2'b10,
        SEL_UPL   = 2'b11
    } sel_t;

    // Output link slots; u1/u2 are the two up-links before randomisation.
    localparam logic [1:0] OUT_L  = 2'd0;
    localparam logic [1:0] OUT_R  = 2'd1;
    localparam logic [1:0] OUT_U1 = 2'd2;
    localparam logic [1:0] OUT_U2 = 2'd3;

    // Input link slots.
    localparam logic [1:0] IN_L  = 2'd0;
    localparam logic [1:0] IN_R  = 2'd1;
    localparam logic [1:0] IN_UL = 2'd2;
    localparam logic [1:0] IN_UR = 2'd3;

    // Per-output claim flags and source selects, plus the output each input won.
    typedef struct packed {
        logic [3:0]       vld;
        logic [3:0][1:0]  src;
        logic [3:0][1:0]  dst;
    } alloc_t;

    function automatic int valid_bit(input int packet_width);
        return packet_width - 1;
    endfunction

    function automatic int addr_msb(input int packet_width);
        return packet_width - 2;
    endfunction

    function automatic sel_t input_sel(input logic [1:0] in_idx);
        sel_t s;
        case (in_idx)
            IN_L:    s = SEL_LEFT;
            IN_R:    s = SEL_RIGHT;
            IN_UL:   s = SEL_UPL;
            default: s = SEL_UPR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pi_switch_sched_decode.sv
// Address-to-direction decode for one input link: packets whose destination
// lies outside this switch's subtree go UP, otherwise the bit just below the
// subtree prefix picks the LEFT or RIGHT child.
module pi_route_decode
    import pi_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1,
    parameter int POS        = 0
) (
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    output dir_t                  dir
);

    localparam int HI_W = ADDR_WIDTH - LEVEL;
    localparam logic [HI_W-1:0] POS_V = HI_W'(POS);

    // Classify the packet by comparing its address prefix with this switch.
    always_comb begin
        dir = VOID;
        if (valid) begin
            if (addr[ADDR_WIDTH-1:LEVEL] != POS_V)
                dir = UP;
            else if (addr[LEVEL-1])
                dir = RIGHT;
            else
                dir = LEFT;
        end
    end

endmodule

// File: rtl/pi_switch_sched.sv
// Deflection scheduler for one pi switch. Stage 1 registers the four input
// packets with their decoded directions; stage 2 assigns every valid packet
// to a distinct output by fixed class priority, drives the registered
// crossbar, randomises the up-links with an LFSR and counts deflections.
module pi_switch_sched
    import pi_sched_pkg::*;
#(
    parameter int          PACKET_WIDTH = 49,
    parameter int          ADDR_WIDTH   = 5,
    parameter int          LEVEL        = 1,
    parameter int          POS          = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_WIDTH-1:0] in_l,
    input  logic [PACKET_WIDTH-1:0] in_r,
    input  logic [PACKET_WIDTH-1:0] in_ul,
    input  logic [PACKET_WIDTH-1:0] in_ur,
    output logic [PACKET_WIDTH-1:0] out_l,
    output logic [PACKET_WIDTH-1:0] out_r,
    output logic [PACKET_WIDTH-1:0] out_ul,
    output logic [PACKET_WIDTH-1:0] out_ur,
    input  logic                    clear_stats,
    output logic [CNT_WIDTH-1:0]    defl_count,
    output logic                    up_toggle
);

    localparam int VB = valid_bit(PACKET_WIDTH);
    localparam int AM = addr_msb(PACKET_WIDTH);

    logic [3:0][PACKET_WIDTH-1:0] in_pkt;
    dir_t                         in_dir [4];
    logic [3:0][PACKET_WIDTH-1:0] s1_pkt;
    dir_t                         s1_dir [4];
    alloc_t                       alloc;
    logic [2:0]                   ndefl;
    logic [3:0][PACKET_WIDTH-1:0] src_pkt;
    logic [3:0][PACKET_WIDTH-1:0] cand;
    logic                         up_used;
    logic                         lfsr_fb;
    logic [15:0]                  lfsr;
    logic [CNT_WIDTH:0]           cnt_sum;

    assign in_pkt = {in_ur, in_ul, in_r, in_l};

    for (genvar g = 0; g < 4; g++) begin : g_decode
        pi_route_decode #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LEVEL      (LEVEL),
            .POS        (POS)
        ) u_decode (
            .valid (in_pkt[g][VB]),
            .addr  (in_pkt[g][AM -: ADDR_WIDTH]),
            .dir   (in_dir[g])
        );
    end

    // Priority pick: first listed output that is still unclaimed.
    function automatic logic [1:0] first_free(input logic [3:0] used,
                                              input logic [1:0] p0, input logic [1:0] p1,
                                              input logic [1:0] p2, input logic [1:0] p3);
        logic [1:0] pick;
        pick = p3;
        if (!used[p2]) pick = p2;
        if (!used[p1]) pick = p1;
        if (!used[p0]) pick = p0;
        return pick;
    endfunction

    function automatic alloc_t claim(input alloc_t a, input logic [1:0] inp,
                                     input logic [1:0] outp);
        alloc_t r;
        r = a;
        r.vld[outp] = 1'b1;
        r.src[outp] = input_sel(inp);
        r.dst[inp]  = outp;
        return r;
    endfunction

    // Class-ordered claims: turnbacks, downlinks, side traffic, then uplinks.
    // With four inputs and four outputs a free slot always remains.
    function automatic alloc_t allocate(input dir_t d_l, input dir_t d_r,
                                        input dir_t d_ul, input dir_t d_ur);
        alloc_t     a;
        logic [1:0] tgt;
        a = '0;
        if (d_l == LEFT)   a = claim(a, IN_L,  OUT_L);
        if (d_r == RIGHT)  a = claim(a, IN_R,  OUT_R);
        if (d_ul == UP)    a = claim(a, IN_UL, OUT_U1);
        if (d_ur == UP)    a = claim(a, IN_UR, OUT_U2);
        if (d_ul == LEFT || d_ul == RIGHT) begin
            tgt = (d_ul == LEFT) ? OUT_L : OUT_R;
            a = claim(a, IN_UL, a.vld[tgt] ?
                      first_free(a.vld, OUT_U1, OUT_U2, OUT_L, OUT_R) : tgt);
        end
        if (d_ur == LEFT || d_ur == RIGHT) begin
            tgt = (d_ur == LEFT) ? OUT_L : OUT_R;
            a = claim(a, IN_UR, a.vld[tgt] ?
                      first_free(a.vld, OUT_U1, OUT_U2, OUT_L, OUT_R) : tgt);
        end
        if (d_l == RIGHT)
            a = claim(a, IN_L, first_free(a.vld, OUT_R, OUT_L, OUT_U1, OUT_U2));
        if (d_r == LEFT)
            a = claim(a, IN_R, first_free(a.vld, OUT_L, OUT_R, OUT_U1, OUT_U2));
        if (d_l == UP)
            a = claim(a, IN_L, first_free(a.vld, OUT_U1, OUT_U2, OUT_L, OUT_R));
        if (d_r == UP)
            a = claim(a, IN_R, first_free(a.vld, OUT_U1, OUT_U2, OUT_R, OUT_L));
        return a;
    endfunction

    // Either up-link satisfies an UP request; side requests need their own link.
    function automatic logic is_defl(input dir_t d, input logic [1:0] o);
        logic res;
        case (d)
            LEFT:    res = (o != OUT_L);
            RIGHT:   res = (o != OUT_R);
            UP:      res = (o != OUT_U1) && (o != OUT_U2);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Stage 1: capture packets and their decoded directions.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_pkt <= '0;
            for (int i = 0; i < 4; i++) s1_dir[i] <= VOID;
        end else begin
            s1_pkt <= in_pkt;
            for (int i = 0; i < 4; i++) s1_dir[i] <= in_dir[i];
        end
    end

    // Stage 2 combinational: allocation, crossbar candidates, deflection count.
    always_comb begin
        alloc = allocate(s1_dir[IN_L], s1_dir[IN_R], s1_dir[IN_UL], s1_dir[IN_UR]);
        ndefl = 3'd0;
        for (int i = 0; i < 4; i++)
            ndefl = ndefl + 3'(is_defl(s1_dir[i], alloc.dst[i]));
        src_pkt[SEL_UPR]   = s1_pkt[IN_UR];
        src_pkt[SEL_LEFT]  = s1_pkt[IN_L];
        src_pkt[SEL_RIGHT] = s1_pkt[IN_R];
        src_pkt[SEL_UPL]   = s1_pkt[IN_UL];
        for (int o = 0; o < 4; o++)
            cand[o] = alloc.vld[o] ? src_pkt[alloc.src[o]] : '0;
        up_used = alloc.vld[OUT_U1] | alloc.vld[OUT_U2];
        lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        cnt_sum = {1'b0, defl_count} + (CNT_WIDTH+1)'(ndefl);
    end

    // Output crossbar register; the LFSR bit decides which up-link gets u1.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_l  <= '0;
            out_r  <= '0;
            out_ul <= '0;
            out_ur <= '0;
        end else begin
            out_l  <= cand[OUT_L];
            out_r  <= cand[OUT_R];
            out_ul <= lfsr[0] ? cand[OUT_U1] : cand[OUT_U2];
            out_ur <= lfsr[0] ? cand[OUT_U2] : cand[OUT_U1];
        end
    end

    // LFSR advances only when an up-link actually carries a packet.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else if (up_used)
            lfsr <= {lfsr_fb, lfsr[15:1]};
    end

    // Saturating deflection counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear_stats)
            defl_count <= '0;
        else if (cnt_sum[CNT_WIDTH])
            defl_count <= '1;
        else
            defl_count <= cnt_sum[CNT_WIDTH-1:0];
    end

    assign up_toggle = lfsr[0];

endmodule

// File: tb/tb_pi_switch_sched.sv
// Bench for pi_switch_sched: a behavioural model of the two-stage scheduler
// is compared with the DUT on every cycle, and directed scenarios pin the
// model with hand-computed expectations.
module tb_pi_switch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_stats;
    logic [48:0] in_l, in_r, in_ul, in_ur;
    logic [48:0] out_l, out_r, out_ul, out_ur;
    logic [15:0] defl_count;
    logic        up_toggle;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    pi_switch_sched #(
        .PACKET_WIDTH (49),
        .ADDR_WIDTH   (5),
        .LEVEL        (1),
        .POS          (0),
        .LFSR_SEED    (16'hACE1),
        .CNT_WIDTH    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_l        (in_l),
        .in_r        (in_r),
        .in_ul       (in_ul),
        .in_ur       (in_ur),
        .out_l       (out_l),
        .out_r       (out_r),
        .out_ul      (out_ul),
        .out_ur      (out_ur),
        .clear_stats (clear_stats),
        .defl_count  (defl_count),
        .up_toggle   (up_toggle)
    );

    always #5 clk = ~clk;

    // Behavioural model state: inputs 0=l,1=r,2=ul,3=ur; outputs 0=l,1=r,2=ul,3=ur.
    logic [48:0] m_s1  [4];
    logic [48:0] m_out [4];
    int          m_cnt;
    logic [15:0] m_lfsr;
    int          m_owner [4];
    int          m_asg   [4];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [48:0] l, input logic [48:0] r,
                                  input logic [48:0] ul, input logic [48:0] ur);
        in_l  = l;
        in_r  = r;
        in_ul = ul;
        in_ur = ur;
    endtask

    function automatic logic [48:0] mk(input int addr, input logic [42:0] payload);
        logic [4:0] a;
        a = addr[4:0];
        return {1'b1, a, payload};
    endfunction

    function automatic logic [48:0] rand_pkt();
        logic [4:0]  a;
        logic [42:0] p;
        a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        p = {11'($urandom), $urandom};
        return {1'($urandom_range(0, 1)), a, p};
    endfunction

    // 0 = idle, 1 = left leaf, 2 = right leaf, 3 = leave the subtree.
    function automatic int want(input logic [48:0] pkt);
        int addr;
        addr = int'(pkt[47:43]);
        if (!pkt[48]) return 0;
        if (addr / 2 != 0) return 3;
        return (addr % 2 == 1) ? 2 : 1;
    endfunction

    function automatic void m_take(input int inp, input int p0, input int p1,
                                   input int p2, input int p3, input int p4);
        int p[5];
        p = '{p0, p1, p2, p3, p4};
        for (int k = 0; k < 5; k++) begin
            if (m_owner[p[k]] < 0) begin
                m_owner[p[k]] = inp;
                m_asg[inp]    = p[k];
                return;
            end
        end
    endfunction

    // Reference scheduler evaluated once per clock edge.
    always @(posedge clk) begin
        int          d [4];
        int          nd;
        logic [48:0] u1, u2;
        logic        bitv;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i]  = '0;
                m_out[i] = '0;
            end
            m_cnt  = 0;
            m_lfsr = 16'hACE1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                d[i] = want(m_s1[i]);
                m_owner[i] = -1;
                m_asg[i] = -1;
            end
            if (d[0] == 1) m_take(0, 0, 0, 0, 0, 0);
            if (d[1] == 2) m_take(1, 1, 1, 1, 1, 1);
            if (d[2] == 3) m_take(2, 2, 2, 2, 2, 2);
            if (d[3] == 3) m_take(3, 3, 3, 3, 3, 3);
            for (int i = 2; i < 4; i++)
                if (d[i] == 1 || d[i] == 2) m_take(i, d[i] - 1, 2, 3, 0, 1);
            if (d[0] == 2) m_take(0, 1, 0, 2, 3, 3);
            if (d[1] == 1) m_take(1, 0, 1, 2, 3, 3);
            if (d[0] == 3) m_take(0, 2, 3, 0, 1, 1);
            if (d[1] == 3) m_take(1, 2, 3, 1, 0, 0);
            nd = 0;
            for (int i = 0; i < 4; i++) begin
                if (d[i] == 1 && m_asg[i] != 0) nd++;
                if (d[i] == 2 && m_asg[i] != 1) nd++;
                if (d[i] == 3 && m_asg[i] < 2) nd++;
            end
            m_out[0] = (m_owner[0] >= 0) ? m_s1[m_owner[0]] : '0;
            m_out[1] = (m_owner[1] >= 0) ? m_s1[m_owner[1]] : '0;
            u1 = (m_owner[2] >= 0) ? m_s1[m_owner[2]] : '0;
            u2 = (m_owner[3] >= 0) ? m_s1[m_owner[3]] : '0;
            m_out[2] = m_lfsr[0] ? u1 : u2;
            m_out[3] = m_lfsr[0] ? u2 : u1;
            if (m_owner[2] >= 0 || m_owner[3] >= 0) begin
                bitv   = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                m_lfsr = (m_lfsr >> 1) | {bitv, 15'd0};
            end
            if (clear_stats) m_cnt = 0;
            else m_cnt = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
            m_s1[0] = in_l;
            m_s1[1] = in_r;
            m_s1[2] = in_ul;
            m_s1[3] = in_ur;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("out_l", out_l, m_out[0]);
            check_output("out_r", out_r, m_out[1]);
            check_output("out_ul", out_ul, m_out[2]);
            check_output("out_ur", out_ur, m_out[3]);
            check_output("defl_count", defl_count, 64'(m_cnt));
            check_output("up_toggle", up_toggle, m_lfsr[0]);
        end
    end

    initial begin
        logic [48:0] pa, pb, pc, pd;
        int n;
        reset = 1'b1;
        clear_stats = 1'b0;
        apply_stimulus(mk(0, 43'h0AA), mk(1, 43'h0BB), '0, '0);
        @(negedge clk);
        check_en = 1'b1;

        // Reset held with valid inputs.
        repeat (5) begin
            @(negedge clk);
            check_output("rst_out_l", out_l, 0);
            check_output("rst_out_r", out_r, 0);
            check_output("rst_out_ul", out_ul, 0);
            check_output("rst_out_ur", out_ur, 0);
            check_output("rst_defl", defl_count, 0);
            check_output("rst_toggle", up_toggle, 1);
        end
        reset = 1'b0;
        @(negedge clk);
        check_output("post_rst_out_l", out_l, 0);
        check_output("post_rst_out_r", out_r, 0);
        apply_stimulus('0, '0, '0, '0);
        repeat (3) @(negedge clk);

        // Single packet left-in to right-out.
        apply_stimulus(mk(1, 43'h1234), '0, '0, '0);
        @(negedge clk);
        apply_stimulus('0, '0, '0, '0);
        @(negedge clk);
        check_output("single_out_r", out_r, {1'b1, 5'd1, 43'h1234});
        check_output("single_out_l", out_l, 0);
        check_output("single_out_ul", out_ul, 0);
        check_output("single_defl", defl_count, 0);

        // Swap: side packets cross without deflection.
        pa = mk(1, 43'h111);
        pb = mk(0, 43'h222);
        apply_stimulus(pa, pb, '0, '0);
        @(negedge clk);
        apply_stimulus('0, '0, '0, '0);
        @(negedge clk);
        check_output("swap_out_r", out_r, {1'b1, 5'd1, 43'h111});
        check_output("swap_out_l", out_l, {1'b1, 5'd0, 43'h222});
        check_output("swap_defl", defl_count, 0);

        // Full contention: all four want LEFT, three deflect.
        pa = mk(0, 43'hA1);
        pb = mk(0, 43'hB2);
        pc = mk(0, 43'hC3);
        pd = mk(0, 43'hD4);
        apply_stimulus(pa, pb, pc, pd);
        @(negedge clk);
        apply_stimulus('0, '0, '0, '0);
        @(negedge clk);
        check_output("full_out_l", out_l, {1'b1, 5'd0, 43'hA1});
        check_output("full_out_r", out_r, {1'b1, 5'd0, 43'hB2});
        check_output("full_out_ul", out_ul, {1'b1, 5'd0, 43'hC3});
        check_output("full_out_ur", out_ur, {1'b1, 5'd0, 43'hD4});
        check_output("full_defl", defl_count, 3);
        check_output("full_toggle", up_toggle, 0);

        // Up traffic for 8 cycles; LFSR 0x5670 sends the first to out_ur.
        apply_stimulus(mk(4, 43'h300), '0, '0, '0);
        @(negedge clk);
        apply_stimulus(mk(4, 43'h301), '0, '0, '0);
        @(negedge clk);
        check_output("tog_first_ur", out_ur, {1'b1, 5'd4, 43'h300});
        check_output("tog_first_ul", out_ul, 0);
        for (int k = 2; k < 8; k++) begin
            apply_stimulus(mk(4, 43'(k + 'h300)), '0, '0, '0);
            @(negedge clk);
        end
        apply_stimulus('0, '0, '0, '0);
        repeat (5) @(negedge clk);

        // Randomised traffic with occasional clears and resets.
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus(rand_pkt(), rand_pkt(), rand_pkt(), rand_pkt());
            clear_stats = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        clear_stats = 1'b0;

        // Saturation: sustained full contention until the counter pins.
        apply_stimulus(pa, pb, pc, pd);
        n = 0;
        while (defl_count !== 16'hFFFF && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check_output("sat_reach", defl_count, 16'hFFFF);
        repeat (3) @(negedge clk);
        check_output("sat_hold", defl_count, 16'hFFFF);
        clear_stats = 1'b1;
        @(negedge clk);
        check_output("clear_wins", defl_count, 0);
        clear_stats = 1'b0;
        @(negedge clk);
        check_output("after_clear", defl_count, 3);
        apply_stimulus('0, '0, '0, '0);
        repeat (4) @(negedge clk);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
